// File: rtl/enemy_pkg.sv
// Shared definitions for the enemy block: the sequencer state encoding, the
// movement/facing codes used by the enemy datapath, the sprite geometry, and
// the one-hot strobe bundle that the sequencer drives into the datapath.
package enemy_pkg;

    // Sequencer states; 3-bit encoding shared with the datapath and debug logic.
    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_GEN   = 3'd2,
        S_CHECK = 3'd3,
        S_MOVE  = 3'd4,
        S_DRAW  = 3'd5,
        S_DONE  = 3'd6
    } enemy_state_e;

    // Movement decision produced by the enemy move generator.
    typedef enum logic [2:0] {
        NO_ACTION = 3'd0,
        ATTACK    = 3'd1,
        UP        = 3'd2,
        DOWN      = 3'd3,
        LEFT      = 3'd4,
        RIGHT     = 3'd5
    } enemy_dir_e;

    // Direction the enemy sprite faces; selects the sprite variant to draw.
    typedef enum logic [1:0] {
        FACE_UP    = 2'd0,
        FACE_DOWN  = 2'd1,
        FACE_LEFT  = 2'd2,
        FACE_RIGHT = 2'd3
    } enemy_facing_e;

    // Pixels in one enemy sprite; the datapath needs one extra cycle to
    // raise draw_done, so a full draw occupies SPRITE_PIXELS + 1 cycles.
    localparam int SPRITE_PIXELS = 256;

    // Output strobes of the sequencer, held together so that they can be
    // decoded from a state and registered as a single value.
    typedef struct packed {
        logic init;
        logic idle;
        logic gen_move;
        logic move_enemies;
        logic draw_enemies;
        logic enemy_done;
    } enemy_strobes_t;

    // Moore decode: the strobe pattern that belongs to each state.
    function automatic enemy_strobes_t decode_state(input enemy_state_e s);
        enemy_strobes_t o;
        o = '0;
        case (s)
            S_INIT:  o.init         = 1'b1;
            S_IDLE:  o.idle         = 1'b1;
            S_GEN:   o.gen_move     = 1'b1;
            S_MOVE:  o.move_enemies = 1'b1;
            S_DRAW:  o.draw_enemies = 1'b1;
            S_DONE:  o.enemy_done   = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/enemy_if.sv
// Signal bundle between the enemy sequencer and its neighbours: the frame
// sequencer (start / enemy_done) and the enemy datapath (strobes / draw_done).
interface enemy_if;

    logic start;
    logic draw_done;
    logic init;
    logic idle;
    logic gen_move;
    logic move_enemies;
    logic draw_enemies;
    logic enemy_done;
    logic draw_error;
    logic overrun;

    // The sequencer: consumes start/draw_done, drives every strobe and flag.
    modport master (
        input  start,
        input  draw_done,
        output init,
        output idle,
        output gen_move,
        output move_enemies,
        output draw_enemies,
        output enemy_done,
        output draw_error,
        output overrun
    );

    // The surrounding logic: frame sequencer and enemy datapath.
    modport slave (
        output start,
        output draw_done,
        input  init,
        input  idle,
        input  gen_move,
        input  move_enemies,
        input  draw_enemies,
        input  enemy_done,
        input  draw_error,
        input  overrun
    );

endinterface

// File: rtl/enemy_control.sv
// Enemy turn sequencer. Each accepted start either redraws the enemies or,
// on every MOVE_DIVth start, generates a move, waits for the collision
// detector to settle, commits the move and then redraws. Strobes are
// registered one-hot outputs decoded from the state being entered.
module enemy_control
    import enemy_pkg::*;
#(
    parameter int MOVE_DIV     = 4,   // 1..255
    parameter int CHECK_CYCLES = 2,   // 1..15
    parameter int DRAW_TIMEOUT = 512  // must exceed SPRITE_PIXELS + 1
) (
    input  logic   clock,
    input  logic   reset,             // asynchronous, active low
    enemy_if.master bus
);

    localparam logic [7:0] FRAME_LAST = 8'(MOVE_DIV - 1);
    localparam logic [9:0] CHECK_LAST = 10'(CHECK_CYCLES - 1);
    localparam logic [9:0] DRAW_LAST  = 10'(DRAW_TIMEOUT - 1);

    enemy_state_e   state, next_state;
    logic [7:0]     frame_cnt, frame_cnt_nxt;
    logic [9:0]     wait_cnt, wait_cnt_nxt;
    enemy_strobes_t strobes_q;
    logic           draw_error_q, overrun_q;
    logic           timeout_hit;
    logic           start_dropped;

    // Next-state, frame divider and wait counter logic.
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis would infer a latch to hold it.
    always_comb begin
        next_state    = state;
        frame_cnt_nxt = frame_cnt;
        timeout_hit   = 1'b0;

        case (state)
            // The registered init strobe going high marks the single init
            // cycle; leave on the following edge.
            S_INIT: begin
                if (strobes_q.init) next_state = S_IDLE;
            end

            S_IDLE: begin
                if (bus.start) begin
                    if (frame_cnt == FRAME_LAST) begin
                        frame_cnt_nxt = '0;
                        next_state    = S_GEN;
                    end else begin
                        frame_cnt_nxt = frame_cnt + 8'd1;
                        next_state    = S_DRAW;
                    end
                end
            end

            S_GEN: next_state = S_CHECK;

            S_CHECK: begin
                if (wait_cnt == CHECK_LAST) next_state = S_MOVE;
            end

            S_MOVE: next_state = S_DRAW;

            // draw_done on the first draw cycle is left over from the last
            // turn; it is honoured only once wait_cnt has moved off zero, and
            // it wins over a timeout landing on the same cycle.
            S_DRAW: begin
                if (bus.draw_done && (wait_cnt != 10'd0)) begin
                    next_state = S_DONE;
                end else if (wait_cnt == DRAW_LAST) begin
                    timeout_hit = 1'b1;
                    next_state  = S_DONE;
                end
            end

            S_DONE: next_state = S_IDLE;

            default: next_state = S_INIT;
        endcase

        // wait_cnt restarts from zero on every state change.
        if (next_state != state) begin
            wait_cnt_nxt = '0;
        end else begin
            wait_cnt_nxt = wait_cnt + 10'd1;
        end
    end

    // Only S_IDLE accepts a start; anywhere else the pulse is lost.
    assign start_dropped = bus.start && (state != S_IDLE);

    // State, counters, registered strobes and sticky error flags.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and evaluation order cannot matter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= S_INIT;
            frame_cnt    <= '0;
            wait_cnt     <= '0;
            strobes_q    <= '0;
            draw_error_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state        <= next_state;
            frame_cnt    <= frame_cnt_nxt;
            wait_cnt     <= wait_cnt_nxt;
            strobes_q    <= decode_state(next_state);
            draw_error_q <= draw_error_q | timeout_hit;
            overrun_q    <= overrun_q | start_dropped;
        end
    end

    assign bus.init         = strobes_q.init;
    assign bus.idle         = strobes_q.idle;
    assign bus.gen_move     = strobes_q.gen_move;
    assign bus.move_enemies = strobes_q.move_enemies;
    assign bus.draw_enemies = strobes_q.draw_enemies;
    assign bus.enemy_done   = strobes_q.enemy_done;
    assign bus.draw_error   = draw_error_q;
    assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_enemy_control.sv
// Directed bench for enemy_control. A main instance (MOVE_DIV=4,
// CHECK_CYCLES=2) runs a sequence of turns against a frame-divider model and
// a scoreboard of expected turn results; a second instance (MOVE_DIV=1,
// CHECK_CYCLES=3) covers the longer collision-settle window.
module tb_enemy_control;
    import enemy_pkg::*;

    localparam int MOVE_DIV     = 4;
    localparam int CHECK_CYCLES = 2;
    localparam int DRAW_TIMEOUT = 512;
    localparam int DRAW_CYCLES  = SPRITE_PIXELS + 1;
    localparam int TURN_BUDGET  = 3000;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    enemy_if bus ();
    enemy_if bus3 ();

    enemy_control #(
        .MOVE_DIV     (MOVE_DIV),
        .CHECK_CYCLES (CHECK_CYCLES),
        .DRAW_TIMEOUT (DRAW_TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    enemy_control #(
        .MOVE_DIV     (1),
        .CHECK_CYCLES (3),
        .DRAW_TIMEOUT (DRAW_TIMEOUT)
    ) dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (bus3)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit moved;
        int latency;
        bit err;
    } exp_t;

    exp_t sb[$];
    int   model_frame = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int hot_count();
        return int'(bus.init) + int'(bus.idle) + int'(bus.gen_move)
             + int'(bus.move_enemies) + int'(bus.draw_enemies);
    endfunction

    // One turn on the main instance. draw_len: draw cycle on which draw_done
    // is raised (-1 = never, 0 = already high when the turn starts).
    // mid_start: draw cycle on which a stray start is pulsed (0 = none).
    task automatic run_turn(input string name, input int draw_len,
                            input int mid_start, input bit exp_err);
        exp_t e, got;
        int   d, c, gen_at, move_at, draw_cycles, multi;
        bit   done_seen;

        e.moved     = (model_frame == MOVE_DIV - 1);
        model_frame = e.moved ? 0 : model_frame + 1;
        d           = (draw_len < 0) ? DRAW_TIMEOUT : ((draw_len < 2) ? 2 : draw_len);
        e.latency   = e.moved ? (1 + CHECK_CYCLES + 1 + d + 1) : (d + 1);
        e.err       = exp_err;
        sb.push_back(e);

        got         = '{moved: 1'b0, latency: 0, err: 1'b0};
        c           = 0;
        gen_at      = -1;
        move_at     = -1;
        draw_cycles = 0;
        multi       = 0;
        done_seen   = 1'b0;

        @(negedge clock);
        bus.start = 1'b1;
        if (draw_len == 0) bus.draw_done = 1'b1;
        while (!done_seen && c < TURN_BUDGET) begin
            @(negedge clock);
            c++;
            bus.start = 1'b0;
            if (bus.draw_enemies) begin
                draw_cycles++;
                if (mid_start > 0 && draw_cycles == mid_start) bus.start = 1'b1;
            end
            if (draw_len >= 0) bus.draw_done = (draw_cycles >= draw_len);
            if (bus.gen_move && gen_at < 0) gen_at = c;
            if (bus.move_enemies && move_at < 0) move_at = c;
            if (hot_count() > 1) multi++;
            if (bus.enemy_done) begin
                done_seen   = 1'b1;
                got.moved   = (gen_at > 0);
                got.latency = c;
                got.err     = bus.draw_error;
            end
        end
        bus.start     = 1'b0;
        bus.draw_done = 1'b0;

        e = sb.pop_front();
        check({name, "_done_seen"}, done_seen, 1);
        check({name, "_moved"}, got.moved, e.moved);
        check({name, "_latency"}, got.latency, e.latency);
        check({name, "_draw_error"}, got.err, e.err);
        check({name, "_one_hot"}, multi, 0);
        if (e.moved) check({name, "_gen_to_move"}, move_at - gen_at, CHECK_CYCLES + 1);

        @(negedge clock);
        check({name, "_back_to_idle"}, bus.idle, 1);
    endtask

    initial begin
        int  init_cycles, idle_cycles, other_cycles, multi, c, gen_at, move_at;
        bit  seen;

        bus.start      = 1'b0;
        bus.draw_done  = 1'b0;
        bus3.start     = 1'b0;
        bus3.draw_done = 1'b0;
        reset          = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        check("reset_outputs",
              {bus.init, bus.idle, bus.gen_move, bus.move_enemies, bus.draw_enemies,
               bus.enemy_done, bus.draw_error, bus.overrun}, 0);

        // Release: one init cycle, then idle with nothing else active
        reset        = 1'b1;
        init_cycles  = 0;
        idle_cycles  = 0;
        other_cycles = 0;
        multi        = 0;
        for (int i = 0; i < 102; i++) begin
            @(negedge clock);
            if (bus.init) init_cycles++;
            if (bus.idle) idle_cycles++;
            if (bus.gen_move || bus.move_enemies || bus.draw_enemies ||
                bus.enemy_done || bus.draw_error || bus.overrun) other_cycles++;
            if (hot_count() > 1) multi++;
        end
        check("release_init_cycles", init_cycles, 1);
        check("release_idle_cycles", idle_cycles, 101);
        check("release_other_outputs", other_cycles, 0);
        check("release_one_hot", multi, 0);

        // CHECK_CYCLES=3 instance: move commits 4 cycles after generation
        @(negedge clock);
        bus3.start     = 1'b1;
        bus3.draw_done = 1'b1;
        c       = 0;
        gen_at  = -1;
        move_at = -1;
        seen    = 1'b0;
        while (!seen && c < 100) begin
            @(negedge clock);
            c++;
            bus3.start = 1'b0;
            if (bus3.gen_move && gen_at < 0) gen_at = c;
            if (bus3.move_enemies && move_at < 0) move_at = c;
            if (bus3.enemy_done) seen = 1'b1;
        end
        bus3.draw_done = 1'b0;
        check("cc3_done_seen", seen, 1);
        check("cc3_gen_at", gen_at, 1);
        check("cc3_gen_to_move", move_at - gen_at, 4);
        check("cc3_latency", c, 1 + 3 + 1 + 2 + 1);

        // Four full turns: only the fourth moves
        run_turn("t1", DRAW_CYCLES, 0, 1'b0);
        run_turn("t2", DRAW_CYCLES, 0, 1'b0);
        run_turn("t3", DRAW_CYCLES, 0, 1'b0);
        run_turn("t4", DRAW_CYCLES, 0, 1'b0);
        check("no_overrun_yet", bus.overrun, 0);

        // Stale draw_done on the first draw cycle is ignored
        run_turn("t5_stale", 0, 0, 1'b0);

        // Stray start mid-draw: flagged, ignored, divider untouched
        run_turn("t6_overrun", DRAW_CYCLES, 10, 1'b0);
        check("overrun_set", bus.overrun, 1);
        run_turn("t7", DRAW_CYCLES, 0, 1'b0);

        // draw_done on the timeout cycle wins; this is a move turn
        run_turn("t8_coincide", DRAW_TIMEOUT, 0, 1'b0);

        // Timeout, then a normal turn keeps the sticky error
        run_turn("t9_timeout", -1, 0, 1'b1);
        run_turn("t10_sticky", DRAW_CYCLES, 0, 1'b1);
        check("overrun_sticky", bus.overrun, 1);

        // Reset asserted mid-draw drops strobes without a clock edge
        @(negedge clock);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.draw_enemies) seen = 1'b1;
            else @(negedge clock);
        end
        check("rst_mid_draw_entered", seen, 1);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_draw_enemies", bus.draw_enemies, 0);
        check("rst_mid_draw_error", bus.draw_error, 0);
        check("rst_mid_overrun", bus.overrun, 0);
        @(negedge clock);
        reset       = 1'b1;
        init_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (bus.init) init_cycles++;
        end
        check("rst_mid_init_cycles", init_cycles, 1);
        check("rst_mid_idle", bus.idle, 1);
        check("rst_mid_error_clear", bus.draw_error, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/enemy_control.md
Name: enemy_control

Overview:
- Sequencing FSM directly upstream of the enemy datapath.
- Generates the one-hot state strobes that the enemy datapath consumes: init, idle, gen_move, move_enemies, draw_enemies.
- Consumes the datapath's draw_done.
- Paces enemy motion to once every MOVE_DIV frame starts, waits out collision-detector latency before committing a move, and reports turn completion to the top-level frame sequencer.

Parameters:
- MOVE_DIV, 4: enemy moves on every MOVE_DIVth accepted start; other starts only redraw. Legal range 1..255.
- CHECK_CYCLES, 2: cycles held in S_CHECK so the collision detector output settles. Legal range 1..15.
- DRAW_TIMEOUT, 512: maximum cycles in S_DRAW before abort. Must exceed the 257-cycle sprite draw.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- start  in  1  one-cycle pulse from frame sequencer: enemy turn may begin
- draw_done  in  1  from enemy datapath; level, high once the 256-pixel draw completes
- init  out  1  enemy datapath initialise strobe
- idle  out  1  high while waiting for start
- gen_move  out  1  one-cycle move-generation strobe
- move_enemies  out  1  one-cycle move-commit strobe
- draw_enemies  out  1  level, held for the whole draw
- enemy_done  out  1  one-cycle pulse: turn finished
- draw_error  out  1  sticky: a draw timed out
- overrun  out  1  sticky: start arrived while busy

Behaviour:
- Outputs are registered and decoded from the registered state (Moore). At most one of init/idle/gen_move/move_enemies/draw_enemies is high in any cycle.
- Reset (reset=0, asynchronous):
  - state=S_INIT; all outputs 0; frame_cnt=0; wait_cnt=0; draw_error=0; overrun=0.
- S_INIT: init=1 for exactly one cycle, then go to S_IDLE. Entered once after reset deassertion.
- S_IDLE: idle=1.
  - On start=1: if frame_cnt==MOVE_DIV-1, set frame_cnt=0 and go to S_GEN; otherwise frame_cnt+=1 and go to S_DRAW.
  - MOVE_DIV=1 means every start moves.
- S_GEN: gen_move=1 for one cycle, then go to S_CHECK with wait_cnt=0.
- S_CHECK: all strobes 0. wait_cnt increments; when wait_cnt==CHECK_CYCLES-1, go to S_MOVE.
- S_MOVE: move_enemies=1 for one cycle, then go to S_DRAW with wait_cnt=0.
- S_DRAW: draw_enemies=1; wait_cnt increments each cycle.
  - If draw_done=1, go to S_DONE. draw_done takes priority over timeout in the same cycle.
  - Else if wait_cnt==DRAW_TIMEOUT-1, set draw_error=1 and go to S_DONE.
  - draw_done sampled high on the first S_DRAW cycle (stale from the previous turn) is ignored; draw_done is only honoured from the second S_DRAW cycle on.
- S_DONE: enemy_done=1 for one cycle, then go to S_IDLE. draw_enemies is low here, which lets the datapath clear draw_done.
- start handling:
  - start in any state other than S_IDLE (including S_INIT) is dropped and sets overrun=1.
  - start in S_DONE is also dropped; the next accepted start needs S_IDLE.
  - overrun and draw_error clear only on reset.
- Counter widths:
  - frame_cnt: 8 bits.
  - wait_cnt: 10 bits, zeroed on every state entry.
  - No wrap is reachable under the legal parameter ranges.
- Latency:
  - Move turn (start to enemy_done): 1 (S_GEN) + CHECK_CYCLES + 1 (S_MOVE) + draw cycles + 1.
  - Redraw-only turn: draw cycles + 1.
- Reset asserted mid-turn: immediate return to S_INIT and all strobes drop asynchronously. After release, one init pulse is issued.

Decomposition:
- Shared package enemy_pkg holds:
  - enemy state encoding (S_INIT, S_IDLE, S_GEN, S_CHECK, S_MOVE, S_DRAW, S_DONE; 3 bits);
  - direction codes (NO_ACTION, ATTACK, UP, DOWN, LEFT, RIGHT; 3 bits);
  - facing codes (2 bits);
  - the sprite draw length constant 256.
- No sub-module. The frame divider and wait counter are inline registers.

Test Plan:
- Reset release, no start: init high exactly 1 cycle, then idle=1 steady for 100 cycles; all other outputs 0.
- MOVE_DIV=4; four start pulses, each turn completed with draw_done after 257 cycles: starts 1-3 produce no gen_move; start 4 produces gen_move, 2 idle cycles, move_enemies, then draw. enemy_done count = 4.
- CHECK_CYCLES=3; single move turn: move_enemies rises exactly 4 cycles after gen_move rises.
- Hold draw_done=0 in S_DRAW: draw_error rises after 512 draw cycles, enemy_done pulses once, FSM returns to idle; draw_error stays 1 across the next normal turn.
- draw_done=1 and the timeout cycle coincide: draw_error stays 0 and enemy_done pulses.
- start pulsed during S_DRAW: overrun=1, the pulse is ignored, the turn completes normally, frame_cnt unchanged.
- Pull reset low mid-S_DRAW: draw_enemies drops with no clock edge; after release, init pulses once and draw_error=0.
